// File: rtl/ser_pkg.sv
// Shared definitions for the PISO serializer: state encoding and the
// helper that sizes the bit counter.
package ser_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } ser_state_t;

  // Smallest r with 2**r >= n; never below 1 so the counter always has a bit.
  function automatic int clog2_w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/det_1101.sv
// Overlapping 1101 sequence detector fed by the serializer. out is
// registered: it is high the cycle after the final '1' of a match is sampled.
module det_1101 (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out
);

  logic [2:0] hist;

  // Keep the last three bits and flag a match when the fourth completes it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist <= 3'b000;
      out  <= 1'b0;
    end else begin
      hist <= {hist[1:0], in};
      out  <= (hist == 3'b110) && in;
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer. Accepts a W-bit word over valid/ready
// and emits one bit per bit_en strobe; back-to-back words run without a gap.
module piso_bit_serializer
  import ser_pkg::*;
#(
  parameter int   W         = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] data_in,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         bit_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         busy
);

  localparam int CW = clog2_w(W);

  ser_state_t    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_nxt;
  logic          accept;

  // Bit currently at the head of the word for the selected bit order.
  function automatic logic head_bit(input logic [W-1:0] v);
    return (MSB_FIRST != 0) ? v[W-1] : v[0];
  endfunction

  // Advance the word by one position, filling the vacated end with 0.
  function automatic logic [W-1:0] shift_word(input logic [W-1:0] v);
    return (MSB_FIRST != 0) ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
  endfunction

  // Ready while idle, or on the edge that consumes the last bit (no gap).
  assign load_ready = rstn && ((state == S_IDLE) || (bit_en && (cnt == '0)));
  assign accept     = load_valid && load_ready;
  assign shreg_nxt  = shift_word(shreg);
  assign busy       = (state == S_SHIFT);

  // Load/shift state machine with registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else if (accept) begin
      state     <= S_SHIFT;
      shreg     <= data_in;
      cnt       <= CW'(W - 1);
      ser_out   <= head_bit(data_in);
      ser_valid <= 1'b1;
      ser_last  <= 1'b0;
    end else if ((state == S_SHIFT) && bit_en) begin
      if (cnt != '0) begin
        shreg    <= shreg_nxt;
        cnt      <= cnt - CW'(1);
        ser_out  <= head_bit(shreg_nxt);
        ser_last <= (cnt == CW'(1));
      end else begin
        state     <= S_IDLE;
        ser_out   <= IDLE_BIT;
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench: MSB-first serializer driving det_1101, plus an LSB-first
// serializer for bit-order checks.
module tb_piso_bit_serializer;

  logic       clk;
  logic       rstn;
  logic       bit_en;

  logic [7:0] a_data;
  logic       a_lv, a_lr, a_so, a_sv, a_sl, a_busy;
  logic       det_out;

  logic [7:0] b_data;
  logic       b_lv, b_lr, b_so, b_sv, b_sl, b_busy;

  int vectors;
  int miscompares;

  piso_bit_serializer #(.W(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rstn(rstn), .data_in(a_data), .load_valid(a_lv),
    .load_ready(a_lr), .bit_en(bit_en), .ser_out(a_so), .ser_valid(a_sv),
    .ser_last(a_sl), .busy(a_busy)
  );

  det_1101 u_det (.clk(clk), .rstn(rstn), .in(a_so), .out(det_out));

  piso_bit_serializer #(.W(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .rstn(rstn), .data_in(b_data), .load_valid(b_lv),
    .load_ready(b_lr), .bit_en(bit_en), .ser_out(b_so), .ser_valid(b_sv),
    .ser_last(b_sl), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One or two words on serializer A with bit_en held high; det_exp[i] is the
  // expected detector output at sample i after the first accept edge.
  task automatic send_a(input logic [7:0] w0, input logic [7:0] w1,
                        input bit two, input logic [16:0] det_exp);
    logic [15:0] stream;
    int          n;
    stream = two ? {w0, w1} : {w0, 8'h00};
    n      = two ? 16 : 8;
    bit_en = 1'b1;
    a_data = w0;
    a_lv   = 1'b1;
    chk("lr_idle", a_lr, 1);
    step();
    if (two) a_data = w1;
    else     a_lv   = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("bit", a_so, stream[15-i]);
      chk("valid", a_sv, 1);
      chk("busy", a_busy, 1);
      chk("last", a_sl, ((i % 8) == 7) ? 1 : 0);
      chk("lr_shift", a_lr, ((i % 8) == 7) ? 1 : 0);
      chk("det", det_out, det_exp[i]);
      if (i == 8) a_lv = 1'b0;
      step();
    end
    chk("end_so", a_so, 0);
    chk("end_valid", a_sv, 0);
    chk("end_busy", a_busy, 0);
    chk("end_last", a_sl, 0);
    chk("end_det", det_out, det_exp[n]);
    idle_cycles(4);
  endtask

  initial begin
    logic [7:0] w;
    int         k;
    bit         consumed;
    vectors     = 0;
    miscompares = 0;
    rstn   = 1'b0;
    bit_en = 1'b1;
    a_data = 8'h00; a_lv = 1'b0;
    b_data = 8'h00; b_lv = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_so", a_so, 0);
    chk("rst_valid", a_sv, 0);
    chk("rst_last", a_sl, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_lr", a_lr, 0);
    chk("rst_det", det_out, 0);
    rstn = 1'b1;
    #1;
    chk("post_rst_lr", a_lr, 1);

    // 1: single word D0, detector fires once after bit 4
    send_a(8'hD0, 8'h00, 1'b0, 17'h00010);
    // 2: back-to-back 0D,0D
    send_a(8'h0D, 8'h0D, 1'b1, 17'h10100);
    // 3: 03 then 40, match straddles the word boundary
    send_a(8'h03, 8'h40, 1'b1, 17'h00400);

    // 4: bit_en pattern 1,0,0 repeating; bit_en low on the accept edge
    w      = 8'hD0;
    a_data = w;
    a_lv   = 1'b1;
    bit_en = 1'b0;
    step();
    a_lv = 1'b0;
    k    = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      chk("t4_bit", a_so, w[7-k]);
      chk("t4_valid", a_sv, 1);
      chk("t4_last", a_sl, (k == 7) ? 1 : 0);
      consumed = ((c % 3) == 0);
      bit_en   = consumed;
      step();
      if (consumed) k++;
    end
    chk("t4_count", k, 8);
    chk("t4_end_valid", a_sv, 0);
    chk("t4_end_so", a_so, 0);
    bit_en = 1'b1;
    idle_cycles(4);

    // 5: LSB-first instance, 0B -> 1,1,0,1,0,0,0,0
    w      = 8'hD0;
    b_data = 8'h0B;
    b_lv   = 1'b1;
    chk("t5_lr", b_lr, 1);
    step();
    b_lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_bit", b_so, w[7-i]);
      chk("t5_valid", b_sv, 1);
      chk("t5_last", b_sl, (i == 7) ? 1 : 0);
      step();
    end
    chk("t5_end_valid", b_sv, 0);
    chk("t5_end_so", b_so, 0);
    idle_cycles(2);

    // 6: reset after the third bit of FF with a word offered during reset
    a_data = 8'hFF;
    a_lv   = 1'b1;
    step();
    a_lv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_bit", a_so, 1);
      if (i < 2) step();
    end
    rstn = 1'b0;
    a_lv = 1'b1;
    #1;
    chk("t6_lr_rst", a_lr, 0);
    chk("t6_lrb_rst", b_lr, 0);
    step();
    chk("t6_so", a_so, 0);
    chk("t6_valid", a_sv, 0);
    chk("t6_busy", a_busy, 0);
    chk("t6_last", a_sl, 0);
    chk("t6_lr_hold", a_lr, 0);
    rstn = 1'b1;
    #1;
    chk("t6_lr_rel", a_lr, 1);
    step();
    a_lv = 1'b0;
    chk("t6_resume_so", a_so, 1);
    chk("t6_resume_busy", a_busy, 1);
    idle_cycles(8);
    chk("t6_done_valid", a_sv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
